key_ctrl: RTL and testbench

KEY_CTRL -- requirements
Module: key_ctrl

---
 rtl/key_ctrl.sv | 153 +++++++++++++++
 tb/tb_key_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/key_ctrl.sv
// rtl/key_ctrl.sv - three-key debounce, arbitration and auto-repeat pulse controller
module key_ctrl #(
    parameter int DEB_CYCLES = 250000,
    parameter int REP_DELAY  = 25000000,
    parameter int REP_PERIOD = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_clr_n,
    input  logic       key_inc_n,
    input  logic       key_dec_n,
    output logic       clr_pulse,
    output logic       inc_pulse,
    output logic       dec_pulse,
    output logic [2:0] state
);

    localparam int MAX_DR  = (DEB_CYCLES > REP_DELAY) ? DEB_CYCLES : REP_DELAY;
    localparam int MAX_CYC = (MAX_DR > REP_PERIOD) ? MAX_DR : REP_PERIOD;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0] DEB_LOAD    = TW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] DELAY_LOAD  = TW'(REP_DELAY - 1);
    localparam logic [TW-1:0] PERIOD_LOAD = TW'(REP_PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DEB    = 3'd1,
        S_HOLD   = 3'd2,
        S_REPEAT = 3'd3,
        S_REL    = 3'd4
    } fsm_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_CLR  = 2'd1,
        SEL_INC  = 2'd2,
        SEL_DEC  = 2'd3
    } sel_t;

    fsm_t          fsm;
    sel_t          sel;
    logic [TW-1:0] timer;
    logic [2:0]    sync1;
    logic [2:0]    sync2;
    logic [2:0]    pressed;
    logic          sel_pressed;
    logic [2:0]    pulse_q;

    // Bit order everywhere: [2]=clr, [1]=inc, [0]=dec
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
        end else begin
            sync1 <= {key_clr_n, key_inc_n, key_dec_n};
            sync2 <= sync1;
        end
    end

    assign pressed = ~sync2;

    always_comb begin
        sel_pressed = 1'b0;
        case (sel)
            SEL_CLR: sel_pressed = pressed[2];
            SEL_INC: sel_pressed = pressed[1];
            SEL_DEC: sel_pressed = pressed[0];
            default: sel_pressed = 1'b0;
        endcase
    end

    function automatic logic [2:0] pulse_of(input sel_t s);
        case (s)
            SEL_CLR: return 3'b100;
            SEL_INC: return 3'b010;
            SEL_DEC: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm     <= S_IDLE;
            sel     <= SEL_NONE;
            timer   <= '0;
            pulse_q <= 3'b000;
        end else begin
            pulse_q <= 3'b000;
            case (fsm)
                S_IDLE: begin
                    if (|pressed) begin
                        sel   <= pressed[2] ? SEL_CLR : (pressed[1] ? SEL_INC : SEL_DEC);
                        timer <= DEB_LOAD;
                        fsm   <= S_DEB;
                    end
                end
                S_DEB: begin
                    if (!sel_pressed) begin
                        sel   <= SEL_NONE;
                        timer <= '0;
                        fsm   <= S_IDLE;
                    end else if (timer == '0) begin
                        pulse_q <= pulse_of(sel);
                        // Clear never auto-repeats; it just waits for release
                        if (sel == SEL_CLR) begin
                            timer <= DEB_LOAD;
                            fsm   <= S_REL;
                        end else begin
                            timer <= DELAY_LOAD;
                            fsm   <= S_HOLD;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_HOLD, S_REPEAT: begin
                    if (!sel_pressed) begin
                        timer <= DEB_LOAD;
                        fsm   <= S_REL;
                    end else if (timer == '0) begin
                        pulse_q <= pulse_of(sel);
                        timer   <= PERIOD_LOAD;
                        fsm     <= S_REPEAT;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                S_REL: begin
                    if (|pressed) begin
                        timer <= DEB_LOAD;
                    end else if (timer == '0) begin
                        sel <= SEL_NONE;
                        fsm <= S_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    sel   <= SEL_NONE;
                    timer <= '0;
                    fsm   <= S_IDLE;
                end
            endcase
        end
    end

    assign state     = fsm;
    assign clr_pulse = pulse_q[2];
    assign inc_pulse = pulse_q[1];
    assign dec_pulse = pulse_q[0];

endmodule

// File: tb/tb_key_ctrl.sv
// tb/tb_key_ctrl.sv - self-checking bench for key_ctrl
module tb_key_ctrl;

    localparam int DEB    = 4;
    localparam int DELAY  = 10;
    localparam int PERIOD = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key_clr_n, key_inc_n, key_dec_n;
    logic       clr_pulse, inc_pulse, dec_pulse;
    logic [2:0] state;
    logic [2:0] pulses;

    key_ctrl #(.DEB_CYCLES(DEB), .REP_DELAY(DELAY), .REP_PERIOD(PERIOD)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_clr_n(key_clr_n), .key_inc_n(key_inc_n), .key_dec_n(key_dec_n),
        .clr_pulse(clr_pulse), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
        .state(state)
    );

    always #5 clk = ~clk;
    assign pulses = {clr_pulse, inc_pulse, dec_pulse};

    typedef struct { int edge_no; logic [2:0] pulses; } exp_t;
    typedef struct { logic [2:0] keys; int hold; } vec_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   ecount;

    task automatic set_keys(input logic [2:0] k);
        {key_clr_n, key_inc_n, key_dec_n} = ~k;
    endtask

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Every cycle: exclusivity check, and any pulse is matched against the scoreboard
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        ecount++;
        total++;
        if ($countones(pulses) > 1) begin
            bad++;
            $display("FAIL overlap edge=%0d actual=%b required=at most one bit", ecount, pulses);
        end
        if (pulses != 3'b000) begin
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse edge=%0d actual=%b required=none", ecount, pulses);
            end else begin
                e = sbq.pop_front();
                if (e.edge_no != ecount || e.pulses != pulses) begin
                    bad++;
                    $display("FAIL pulse actual=edge%0d/%b required=edge%0d/%b",
                             ecount, pulses, e.edge_no, e.pulses);
                end
            end
        end
    endtask

    task automatic sb_empty(input string nm);
        check({nm, "_missing_pulses"}, sbq.size(), 0);
        sbq.delete();
    endtask

    task automatic wait_idle(input string nm, input int budget);
        for (int i = 0; i < budget && state != 3'd0; i++) tick();
        check({nm, "_idle"}, int'(state), 0);
    endtask

    // Reference: first pulse DEB+3 edges after the first low sample, then DELAY, then every PERIOD,
    // as long as the pulse edge is no later than hold+2 (two synchronizer stages of latency)
    task automatic model(input logic [2:0] keys, input int hold, output int n, output logic is_clr);
        logic [2:0] w;
        int e;
        exp_t x;
        n = 0;
        is_clr = keys[2];
        w = keys[2] ? 3'b100 : (keys[1] ? 3'b010 : 3'b001);
        e = DEB + 3;
        if (e <= hold + 2) begin
            x.edge_no = e; x.pulses = w; sbq.push_back(x); n++;
            if (!is_clr) begin
                e += DELAY;
                while (e <= hold + 2) begin
                    x.edge_no = e; x.pulses = w; sbq.push_back(x); n++;
                    e += PERIOD;
                end
            end
        end
    endtask

    vec_t vecs[8];

    initial begin
        int n;
        logic is_clr;
        int exp_state;
        int sb;
        logic lvl;
        int run;
        exp_t x;

        vecs[0] = '{3'b010, 2};
        vecs[1] = '{3'b010, 4};
        vecs[2] = '{3'b010, 5};
        vecs[3] = '{3'b010, 29};
        vecs[4] = '{3'b101, 20};
        vecs[5] = '{3'b001, 16};
        vecs[6] = '{3'b011, 19};
        vecs[7] = '{3'b111, 8};

        rst_n = 1'b0;
        set_keys(3'b000);
        ecount = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", int'(state), 0);
        check("reset_pulses", int'(pulses), 0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("post_reset_state", int'(state), 0);

        foreach (vecs[v]) begin
            ecount = 0;
            model(vecs[v].keys, vecs[v].hold, n, is_clr);
            set_keys(vecs[v].keys);
            for (int c = 1; c <= vecs[v].hold + 3; c++) begin
                tick();
                if (c == vecs[v].hold) set_keys(3'b000);
                if (c == vecs[v].hold + 2) begin
                    exp_state = (n == 0) ? 1 : (is_clr ? 4 : (n == 1 ? 2 : 3));
                    check($sformatf("vec%0d_held_state", v), int'(state), exp_state);
                end
                if (c == vecs[v].hold + 3)
                    check($sformatf("vec%0d_release_state", v), int'(state), (n == 0) ? 0 : 4);
            end
            wait_idle($sformatf("vec%0d", v), 20);
            sb_empty($sformatf("vec%0d", v));
        end

        // Reset in the middle of a held dec key
        ecount = 0;
        set_keys(3'b001);
        x.edge_no = DEB + 3; x.pulses = 3'b001; sbq.push_back(x);
        repeat (14) tick();
        check("pre_reset_state", int'(state), 2);
        rst_n = 1'b0;
        tick();
        check("in_reset_state", int'(state), 0);
        check("in_reset_pulses", int'(pulses), 0);
        tick();
        check("in_reset_state2", int'(state), 0);
        rst_n = 1'b1;
        x.edge_no = 16 + DEB + 3; x.pulses = 3'b001; sbq.push_back(x);
        while (ecount < 30) tick();
        check("after_reset_state", int'(state), 2);
        set_keys(3'b000);
        wait_idle("reset_seq", 20);
        sb_empty("reset_seq");

        // Bounce: low runs of at most 3 cycles never qualify, then stable low
        ecount = 0;
        lvl = 1'b1;
        while (ecount < 20) begin
            set_keys(lvl ? 3'b010 : 3'b000);
            run = $urandom_range(1, 3);
            repeat (run) tick();
            lvl = ~lvl;
        end
        set_keys(3'b000);
        tick();
        tick();
        sb = ecount + 1;
        set_keys(3'b010);
        x.edge_no = sb + DEB + 2; x.pulses = 3'b010; sbq.push_back(x);
        while (ecount < sb + 12) tick();
        check("bounce_hold_state", int'(state), 2);
        set_keys(3'b000);
        wait_idle("bounce", 20);
        sb_empty("bounce");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
